// File: rtl/csr_trap_ctrl_if.sv
// Trap controller <-> CSR register file handshake: enables in, excep vector and mret select out.
interface csr_trap_ctrl_if #(
  parameter int unsigned width = 32
);
  logic             mstatus_mie;
  logic             mie_mtie;
  logic             mie_meie;
  logic             excep_taken;
  logic [width-1:0] excep;
  logic             is_mret;
  logic             trap_active;
  logic [3:0]       irq_cause;

  modport master (
    input  mstatus_mie, mie_mtie, mie_meie, excep_taken,
    output excep, is_mret, trap_active, irq_cause
  );

  modport slave (
    output mstatus_mie, mie_mtie, mie_meie, excep_taken,
    input  excep, is_mret, trap_active, irq_cause
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode interrupt entry / mret exit sequencer: synchronise, mask, prioritise,
// drain the pipeline, hand a one-hot excep vector to the CSR file and flush the front end.
module csr_trap_ctrl #(
  parameter int unsigned width        = 32,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              timer_irq,
  input  logic              ext_irq,
  input  logic              instr_valid_wb,
  input  logic              is_mret_wb,
  output logic              stall_req,
  output logic              flush,
  csr_trap_ctrl_if.master   csr
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DRAIN    = 3'd1;
  localparam logic [2:0] S_COMMIT   = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_IN_TRAP  = 3'd4;
  localparam logic [2:0] S_MRET     = 3'd5;

  localparam logic [3:0] CAUSE_TMR = 4'd7;
  localparam logic [3:0] CAUSE_EXT = 4'd11;

  logic [SYNC_STAGES-1:0] tmr_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic [2:0]             state;
  logic [3:0]             cnt;
  logic [3:0]             pend_cause;
  logic [3:0]             cause_q;
  logic                   active_q;

  logic       sync_tmr;
  logic       sync_ext;
  logic       tmr_req;
  logic       ext_req;
  logic       any_req;
  logic       mret_wb;
  logic [3:0] prio_cause;
  logic [3:0] commit_cause;
  logic [3:0] excep_cause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_sync <= '0;
      ext_sync <= '0;
    end else begin
      tmr_sync <= {tmr_sync[SYNC_STAGES-2:0], timer_irq};
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_irq};
    end
  end

  assign sync_tmr   = tmr_sync[SYNC_STAGES-1];
  assign sync_ext   = ext_sync[SYNC_STAGES-1];
  assign ext_req    = sync_ext & csr.mie_meie & csr.mstatus_mie;
  assign tmr_req    = sync_tmr & csr.mie_mtie & csr.mstatus_mie;
  assign any_req    = ext_req | tmr_req;
  assign mret_wb    = instr_valid_wb & is_mret_wb;
  assign prio_cause = ext_req ? CAUSE_EXT : CAUSE_TMR;

  // The commit-cycle priority is final; if both requests vanish exactly at commit,
  // fall back to the last cause seen while draining so excep stays one-hot.
  assign commit_cause = any_req ? prio_cause : pend_cause;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pend_cause <= '0;
      cause_q    <= '0;
      active_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mret_wb && active_q) begin
            state <= S_MRET;
          end else if (any_req && !active_q) begin
            state      <= S_DRAIN;
            cnt        <= 4'(DRAIN_CYCLES - 1);
            pend_cause <= prio_cause;
          end
        end
        S_DRAIN: begin
          if (!any_req) begin
            state <= S_IDLE;
          end else begin
            pend_cause <= prio_cause;
            if (cnt == '0) state <= S_COMMIT;
            else           cnt   <= cnt - 4'd1;
          end
        end
        S_COMMIT: begin
          cause_q  <= commit_cause;
          active_q <= 1'b1;
          state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (csr.excep_taken) state <= S_IN_TRAP;
        end
        S_IN_TRAP: begin
          if (mret_wb) state <= S_MRET;
        end
        S_MRET: begin
          active_q <= 1'b0;
          cause_q  <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    excep_cause = '0;
    csr.excep   = '0;
    if (state == S_COMMIT) begin
      excep_cause = commit_cause;
      csr.excep   = width'(1) << excep_cause;
    end else if (state == S_WAIT_ACK) begin
      excep_cause = cause_q;
      csr.excep   = width'(1) << excep_cause;
    end
  end

  assign stall_req       = (state == S_DRAIN) | (state == S_COMMIT) | (state == S_WAIT_ACK);
  assign flush           = (state == S_COMMIT) | (state == S_MRET);
  assign csr.is_mret     = (state == S_MRET);
  assign csr.trap_active = active_q;
  assign csr.irq_cause   = cause_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: stimulus queues expected flush events, a monitor checks them.
module tb_csr_trap_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic timer_irq, ext_irq, instr_valid_wb, is_mret_wb;
  logic stall_req, flush;

  always #5 clk = ~clk;

  csr_trap_ctrl_if #(.width(32)) csr_bus();

  csr_trap_ctrl #(
    .width(32),
    .DRAIN_CYCLES(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .timer_irq      (timer_irq),
    .ext_irq        (ext_irq),
    .instr_valid_wb (instr_valid_wb),
    .is_mret_wb     (is_mret_wb),
    .stall_req      (stall_req),
    .flush          (flush),
    .csr            (csr_bus)
  );

  typedef struct packed {
    logic        mret;
    logic [31:0] excep;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flush(input string name);
    int n = 0;
    while (!flush && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_flush_seen"}, 32'(flush), 32'd1);
  endtask

  // Lines already raised by caller; commits, acknowledges and drops both lines.
  task automatic take_trap(input string name, input logic [31:0] vec, input logic [3:0] cause);
    exp_q.push_back('{mret: 1'b0, excep: vec});
    wait_flush(name);
    tick();
    chk({name, "_held_excep"}, csr_bus.excep, vec);
    chk({name, "_cause"}, 32'(csr_bus.irq_cause), 32'(cause));
    chk({name, "_active"}, 32'(csr_bus.trap_active), 32'd1);
    csr_bus.excep_taken = 1'b1;
    timer_irq = 1'b0;
    ext_irq   = 1'b0;
    tick();
    csr_bus.excep_taken = 1'b0;
    chk({name, "_excep_cleared"}, csr_bus.excep, 32'h0);
    chk({name, "_stall_released"}, 32'(stall_req), 32'd0);
  endtask

  task automatic do_mret(input string name);
    exp_q.push_back('{mret: 1'b1, excep: 32'h0});
    instr_valid_wb = 1'b1;
    is_mret_wb     = 1'b1;
    tick();
    instr_valid_wb = 1'b0;
    is_mret_wb     = 1'b0;
    chk({name, "_is_mret"}, 32'(csr_bus.is_mret), 32'd1);
    chk({name, "_flush"}, 32'(flush), 32'd1);
    tick();
    chk({name, "_is_mret_pulse"}, 32'(csr_bus.is_mret), 32'd0);
    chk({name, "_inactive"}, 32'(csr_bus.trap_active), 32'd0);
    chk({name, "_cause_cleared"}, 32'(csr_bus.irq_cause), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    timer_irq = 1'b0;
    ext_irq = 1'b0;
    instr_valid_wb = 1'b0;
    is_mret_wb = 1'b0;
    csr_bus.mstatus_mie = 1'b1;
    csr_bus.mie_mtie = 1'b1;
    csr_bus.mie_meie = 1'b1;
    csr_bus.excep_taken = 1'b0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (csr_bus.excep != 32'h0) begin
            chk("mon_onehot", 32'($countones(csr_bus.excep)), 32'd1);
          end
          if (flush) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_flush: got excep %h is_mret %b, expected no flush",
                       csr_bus.excep, csr_bus.is_mret);
            end else begin
              e = exp_q.pop_front();
              chk("mon_is_mret", 32'(csr_bus.is_mret), 32'(e.mret));
              chk("mon_excep", csr_bus.excep, e.excep);
              chk("mon_stall", 32'(stall_req), 32'(!e.mret));
            end
          end
        end
      end
      begin : stimulus
        repeat (3) tick();
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_excep", csr_bus.excep, 32'h0);
        chk("rst_active", 32'(csr_bus.trap_active), 32'd0);
        chk("rst_cause", 32'(csr_bus.irq_cause), 32'd0);
        reset = 1'b1;
        tick();

        // Timer trap, cycle-exact through the synchroniser and drain.
        timer_irq = 1'b1;
        exp_q.push_back('{mret: 1'b0, excep: 32'h80});
        tick();
        chk("s1_sync1_idle", 32'(stall_req), 32'd0);
        tick();
        chk("s1_sync2_idle", 32'(stall_req), 32'd0);
        tick();
        chk("s1_drain1_stall", 32'(stall_req), 32'd1);
        chk("s1_drain1_excep", csr_bus.excep, 32'h0);
        tick();
        chk("s1_drain2_stall", 32'(stall_req), 32'd1);
        chk("s1_drain2_flush", 32'(flush), 32'd0);
        tick();
        chk("s1_commit_flush", 32'(flush), 32'd1);
        chk("s1_commit_excep", csr_bus.excep, 32'h80);
        tick();
        chk("s1_wait_excep", csr_bus.excep, 32'h80);
        chk("s1_wait_flush", 32'(flush), 32'd0);
        chk("s1_wait_cause", 32'(csr_bus.irq_cause), 32'd7);
        chk("s1_wait_active", 32'(csr_bus.trap_active), 32'd1);
        csr_bus.excep_taken = 1'b1;
        timer_irq = 1'b0;
        tick();
        csr_bus.excep_taken = 1'b0;
        chk("s1_trap_excep", csr_bus.excep, 32'h0);
        chk("s1_trap_stall", 32'(stall_req), 32'd0);
        chk("s1_trap_cause", 32'(csr_bus.irq_cause), 32'd7);
        chk("s1_trap_active", 32'(csr_bus.trap_active), 32'd1);
        do_mret("s1_mret");
        repeat (3) tick();

        // Simultaneous timer + external: external wins, single trap.
        timer_irq = 1'b1;
        ext_irq   = 1'b1;
        take_trap("s2", 32'h800, 4'd11);
        repeat (6) begin
          tick();
          chk("s2_no_second", 32'(stall_req), 32'd0);
        end
        do_mret("s2_mret");
        repeat (3) tick();

        // No nesting; pending external starts DRAIN right after mret.
        timer_irq = 1'b1;
        take_trap("s3a", 32'h80, 4'd7);
        ext_irq = 1'b1;
        repeat (5) begin
          tick();
          chk("s3_no_nest", 32'(stall_req), 32'd0);
        end
        do_mret("s3_mret");
        tick();
        chk("s3_drain_after_mret", 32'(stall_req), 32'd1);
        take_trap("s3b", 32'h800, 4'd11);
        do_mret("s3b_mret");
        repeat (3) tick();

        // Global enable off: request never acted on.
        csr_bus.mstatus_mie = 1'b0;
        timer_irq = 1'b1;
        repeat (8) begin
          tick();
          chk("s4_stall", 32'(stall_req), 32'd0);
          chk("s4_flush", 32'(flush), 32'd0);
          chk("s4_excep", csr_bus.excep, 32'h0);
        end
        timer_irq = 1'b0;
        repeat (4) tick();
        csr_bus.mstatus_mie = 1'b1;

        // One-cycle timer pulse: drain entered then abandoned.
        timer_irq = 1'b1;
        tick();
        timer_irq = 1'b0;
        tick();
        tick();
        chk("s5_drain_entered", 32'(stall_req), 32'd1);
        tick();
        chk("s5_abandon", 32'(stall_req), 32'd0);
        repeat (4) begin
          tick();
          chk("s5_no_excep", csr_bus.excep, 32'h0);
        end

        // Enable cleared during drain: abandon on the next edge.
        timer_irq = 1'b1;
        begin
          int n = 0;
          while (!stall_req && n < 10) begin
            tick();
            n++;
          end
        end
        chk("s5b_drain_entered", 32'(stall_req), 32'd1);
        csr_bus.mie_mtie = 1'b0;
        tick();
        chk("s5b_abandon", 32'(stall_req), 32'd0);
        chk("s5b_excep", csr_bus.excep, 32'h0);
        timer_irq = 1'b0;
        repeat (4) tick();
        csr_bus.mie_mtie = 1'b1;

        // Reset during WAIT_ACK drops everything at once.
        timer_irq = 1'b1;
        exp_q.push_back('{mret: 1'b0, excep: 32'h80});
        wait_flush("s6");
        tick();
        chk("s6_wait_excep", csr_bus.excep, 32'h80);
        #1 reset = 1'b0;
        #1;
        chk("s6_rst_excep", csr_bus.excep, 32'h0);
        chk("s6_rst_stall", 32'(stall_req), 32'd0);
        chk("s6_rst_flush", 32'(flush), 32'd0);
        chk("s6_rst_active", 32'(csr_bus.trap_active), 32'd0);
        chk("s6_rst_cause", 32'(csr_bus.irq_cause), 32'd0);
        timer_irq = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("s6_after_rst_stall", 32'(stall_req), 32'd0);

        // mret with no trap active is ignored.
        instr_valid_wb = 1'b1;
        is_mret_wb     = 1'b1;
        tick();
        instr_valid_wb = 1'b0;
        is_mret_wb     = 1'b0;
        chk("s7_no_is_mret", 32'(csr_bus.is_mret), 32'd0);
        chk("s7_no_flush", 32'(flush), 32'd0);
        repeat (3) tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
